// File: rtl/zero_cross_period_pkg.sv
// Shared types and constants for the zero-crossing period meter.
// Also used by the amplitude-detector stage, which reuses zc_hyst_cmp.
package zero_cross_pkg;

    typedef enum logic [1:0] {
        ZC_UNKNOWN = 2'd0,
        ZC_NEG     = 2'd1,
        ZC_POS     = 2'd2
    } zc_state_e;

    localparam int PERIOD_WIDTH_DFLT = 16;
    localparam int CNT_MAX           = (1 << PERIOD_WIDTH_DFLT) - 1;

endpackage

// File: rtl/zero_cross_period_if.sv
// Sample-side and result-side signals of the zero-crossing period meter.
// master drives the samples; slave is the meter itself.
interface zero_cross_period_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int PERIOD_WIDTH = 16
);

    logic                         ce;
    logic signed [DATA_WIDTH-1:0] din;
    logic [PERIOD_WIDTH-1:0]      period_out;
    logic                         period_valid;
    logic                         polarity;
    logic                         timeout;

    modport master (
        output ce,
        output din,
        input  period_out,
        input  period_valid,
        input  polarity,
        input  timeout
    );

    modport slave (
        input  ce,
        input  din,
        output period_out,
        output period_valid,
        output polarity,
        output timeout
    );

endinterface

// File: rtl/zero_cross_period_hyst_cmp.sv
// Signed compare of a sample against a symmetric +/-HYST band.
// Values inside [-HYST, +HYST] raise neither flag.
module zc_hyst_cmp #(
    parameter int DATA_WIDTH = 16,
    parameter int HYST       = 4
) (
    input  logic signed [DATA_WIDTH-1:0] din_i,
    output logic                         above_o,
    output logic                         below_o
);

    localparam logic signed [DATA_WIDTH-1:0] HystPos = DATA_WIDTH'(HYST);
    localparam logic signed [DATA_WIDTH-1:0] HystNeg = -HystPos;

    assign above_o = (din_i > HystPos);
    assign below_o = (din_i < HystNeg);

endmodule

// File: rtl/zero_cross_period.sv
// Rising zero-crossing detector with hysteresis and period counter.
// Define ZC_AVG4_EN to report the running mean of the last four periods.
module zero_cross_period
    import zero_cross_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int HYST         = 4,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    zero_cross_period_if.slave zc
);

    localparam logic [PERIOD_WIDTH-1:0] CntMax = '1;

    logic      above;
    logic      below;
    logic      crossing;
    logic      accept;
    zc_state_e state_q, state_d;

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic                    timeout_q, timeout_d;
    logic [PERIOD_WIDTH-1:0] periodOut_q, periodOut_d;
    logic                    valid_q, valid_d;
    logic                    polarity_q, polarity_d;

    zc_hyst_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .HYST       (HYST)
    ) u_hyst_cmp (
        .din_i   (zc.din),
        .above_o (above),
        .below_o (below)
    );

    // Only NEG -> POS counts as a crossing; leaving UNKNOWN never does.
    always_comb begin
        state_d  = state_q;
        crossing = 1'b0;
        if (zc.ce) begin
            case (state_q)
                ZC_UNKNOWN: begin
                    if (above)      state_d = ZC_POS;
                    else if (below) state_d = ZC_NEG;
                end
                ZC_NEG: begin
                    if (above) begin
                        state_d  = ZC_POS;
                        crossing = 1'b1;
                    end
                end
                ZC_POS: begin
                    if (below) state_d = ZC_NEG;
                end
                default: state_d = ZC_UNKNOWN;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        timeout_d  = timeout_q;
        accept     = 1'b0;
        polarity_d = (state_d == ZC_POS);
        if (zc.ce) begin
            if (crossing) begin
                cnt_d   = '0;
                armed_d = 1'b1;
                if (timeout_q) timeout_d = 1'b0;
                else if (armed_q) accept = 1'b1;
            end else begin
                if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                if (cnt_d == CntMax) timeout_d = 1'b1;
            end
        end
    end

`ifdef ZC_AVG4_EN
    localparam int SumWidth = PERIOD_WIDTH + 2;

    logic                    acc_q, acc_d;
    logic [PERIOD_WIDTH-1:0] newPer_q, newPer_d;
    logic [PERIOD_WIDTH-1:0] hist_q [4];
    logic [PERIOD_WIDTH-1:0] hist_d [4];
    logic [SumWidth-1:0]     sum_q, sum_d;
    logic [2:0]              fill_q, fill_d;
    logic                    flush;

    // The oldest entry is zero until the history is full, so the
    // running sum is exact while it fills.
    always_comb begin
        acc_d       = accept;
        newPer_d    = accept ? (cnt_q + 1'b1) : newPer_q;
        hist_d      = hist_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        periodOut_d = periodOut_q;
        valid_d     = 1'b0;
        flush       = timeout_d & ~timeout_q;
        if (flush) begin
            hist_d = '{default: '0};
            sum_d  = '0;
            fill_d = '0;
        end else if (acc_q) begin
            hist_d[3] = hist_q[2];
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = newPer_q;
            sum_d     = sum_q + SumWidth'(newPer_q) - SumWidth'(hist_q[3]);
            fill_d    = (fill_q == 3'd4) ? 3'd4 : (fill_q + 3'd1);
            if (fill_d == 3'd4) begin
                valid_d     = 1'b1;
                periodOut_d = sum_d[SumWidth-1:2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= 1'b0;
            newPer_q <= '0;
            hist_q   <= '{default: '0};
            sum_q    <= '0;
            fill_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            newPer_q <= newPer_d;
            hist_q   <= hist_d;
            sum_q    <= sum_d;
            fill_q   <= fill_d;
        end
    end
`else
    // cnt+1 cannot wrap here: a saturated count has already set timeout.
    always_comb begin
        periodOut_d = periodOut_q;
        valid_d     = 1'b0;
        if (accept) begin
            periodOut_d = cnt_q + 1'b1;
            valid_d     = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ZC_UNKNOWN;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            timeout_q   <= 1'b0;
            periodOut_q <= '0;
            valid_q     <= 1'b0;
            polarity_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            timeout_q   <= timeout_d;
            periodOut_q <= periodOut_d;
            valid_q     <= valid_d;
            polarity_q  <= polarity_d;
        end
    end

    assign zc.period_out   = periodOut_q;
    assign zc.period_valid = valid_q;
    assign zc.polarity     = polarity_q;
    assign zc.timeout      = timeout_q;

endmodule

// File: tb/tb_zero_cross_period.sv
// Bench for zero_cross_period: a 16-bit-counter instance for the main
// scenarios and a 4-bit-counter instance for saturation/timeout.
module tb_zero_cross_period;

    localparam int DW   = 16;
    localparam int PW   = 16;
    localparam int PWS  = 4;
    localparam int HYST = 4;

    typedef struct {
        int   din;
        logic pol;
        logic pulse;
        int   per;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #4 clk = ~clk;

    zero_cross_period_if #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW))  busA ();
    zero_cross_period_if #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PWS)) busB ();

    zero_cross_period #(.DATA_WIDTH(DW), .HYST(HYST), .PERIOD_WIDTH(PW)) dutA (
        .clk (clk),
        .rst (rst),
        .zc  (busA)
    );

    zero_cross_period #(.DATA_WIDTH(DW), .HYST(HYST), .PERIOD_WIDTH(PWS)) dutB (
        .clk (clk),
        .rst (rst),
        .zc  (busB)
    );

    int checks = 0;
    int errors = 0;
    int qA[$];
    int qB[$];
    int expA;
    int expB;
    vec_t vecs[$];

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (busA.period_valid === 1'b1) begin
            checks++;
            if (qA.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedPulseA: got period %0d, required no pulse", busA.period_out);
            end else begin
                expA = qA.pop_front();
                if (busA.period_out !== PW'(expA)) begin
                    errors++;
                    $display("[TB] FAIL periodA: got %0d, required %0d", busA.period_out, expA);
                end
            end
        end
        if (busB.period_valid === 1'b1) begin
            checks++;
            if (qB.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedPulseB: got period %0d, required no pulse", busB.period_out);
            end else begin
                expB = qB.pop_front();
                if (busB.period_out !== PWS'(expB)) begin
                    errors++;
                    $display("[TB] FAIL periodB: got %0d, required %0d", busB.period_out, expB);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic checkQueues(input string name);
        checkOutput({name, "_pendingA"}, qA.size(), 0);
        checkOutput({name, "_pendingB"}, qB.size(), 0);
        qA.delete();
        qB.delete();
    endtask

    task automatic checkIdle(input string name, input int which);
        if (which == 0) begin
            checkOutput({name, "_periodA"},   int'(busA.period_out), 0);
            checkOutput({name, "_validA"},    int'(busA.period_valid), 0);
            checkOutput({name, "_polarityA"}, int'(busA.polarity), 0);
            checkOutput({name, "_timeoutA"},  int'(busA.timeout), 0);
        end else begin
            checkOutput({name, "_periodB"},   int'(busB.period_out), 0);
            checkOutput({name, "_validB"},    int'(busB.period_valid), 0);
            checkOutput({name, "_polarityB"}, int'(busB.polarity), 0);
            checkOutput({name, "_timeoutB"},  int'(busB.timeout), 0);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        busA.ce = 1'b0;
        busB.ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One ce strobe every 100 clocks; polarity is checked just after the strobe edge.
    task automatic applyStimulus(input int which, input int d, input logic expPol,
                                 input logic expPulse, input int expPer);
        @(posedge clk);
        #1;
        if (which == 0) begin
            busA.ce  = 1'b1;
            busA.din = DW'(d);
            if (expPulse) qA.push_back(expPer);
        end else begin
            busB.ce  = 1'b1;
            busB.din = DW'(d);
            if (expPulse) qB.push_back(expPer);
        end
        @(posedge clk);
        #1;
        busA.ce = 1'b0;
        busB.ce = 1'b0;
        if (which == 0) checkOutput("polarityA", int'(busA.polarity), int'(expPol));
        else            checkOutput("polarityB", int'(busB.polarity), int'(expPol));
        repeat (98) @(posedge clk);
    endtask

    // P-1 samples (positive half then negative half), then the rising crossing.
    task automatic applyPeriod(input int which, input int p, input logic expPulse, input int expPer);
        for (int j = 1; j < p; j++) begin
            if (j <= (p - 1) / 2) applyStimulus(which, 16, 1'b1, 1'b0, 0);
            else                  applyStimulus(which, -16, 1'b0, 1'b0, 0);
        end
        applyStimulus(which, 16, 1'b1, expPulse, expPer);
    endtask

    task automatic buildSine(input int reps, input int firstPulseRep);
        int   wave [9];
        logic pol  [9];
        wave = '{8, 14, 16, 12, 0, -12, -16, -14, -8};
        pol  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs.delete();
        vecs.push_back('{din: -16, pol: 1'b0, pulse: 1'b0, per: 0});
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 9; i++) begin
                vecs.push_back('{din: wave[i], pol: pol[i],
                                 pulse: (i == 0 && r >= firstPulseRep), per: 9});
            end
        end
    endtask

    task automatic applyVecs(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(0, vecs[i].din, vecs[i].pol, vecs[i].pulse, vecs[i].per);
        end
    endtask

    initial begin
        busA.ce  = 1'b0;
        busA.din = '0;
        busB.ce  = 1'b0;
        busB.din = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset", 0);
        checkIdle("reset", 1);
        rst = 1'b0;

`ifdef ZC_AVG4_EN
        $display("[TB] averaging build: periods 8,10,9,9 then 7");
        applyStimulus(0, -16, 1'b0, 1'b0, 0);
        applyStimulus(0, 16, 1'b1, 1'b0, 0);
        applyPeriod(0, 8, 1'b0, 0);
        applyPeriod(0, 10, 1'b0, 0);
        applyPeriod(0, 9, 1'b0, 0);
        applyPeriod(0, 9, 1'b1, 9);
        applyPeriod(0, 7, 1'b1, 8);
        repeat (5) @(posedge clk);
        checkQueues("avg4");
        checkOutput("avgHeld", int'(busA.period_out), 8);
`else
        $display("[TB] sine, 5 cycles of period 9");
        buildSine(5, 1);
        applyVecs(vecs.size());
        checkQueues("sine");
        checkOutput("sineHeld", int'(busA.period_out), 9);

        $display("[TB] constant 15 after zeros");
        doReset();
        for (int i = 0; i < 3; i++)  applyStimulus(0, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 15, 1'b1, 1'b0, 0);
        checkQueues("const");
        checkOutput("constTimeout", int'(busA.timeout), 0);

        $display("[TB] noise inside the band after NEG");
        doReset();
        applyStimulus(0, -16, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: applyStimulus(0, 3, 1'b0, 1'b0, 0);
                1: applyStimulus(0, -3, 1'b0, 1'b0, 0);
                2: applyStimulus(0, 4, 1'b0, 1'b0, 0);
                default: applyStimulus(0, -4, 1'b0, 1'b0, 0);
            endcase
        end
        applyStimulus(0, 5, 1'b1, 1'b0, 0);
        applyStimulus(0, -5, 1'b0, 1'b0, 0);
        checkQueues("noise");

        $display("[TB] saturation with a 4-bit counter");
        doReset();
        applyStimulus(1, -16, 1'b0, 1'b0, 0);
        applyStimulus(1, 16, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1, -15, 1'b0, 1'b0, 0);
            checkOutput("timeoutB", int'(busB.timeout), (k >= 15) ? 1 : 0);
        end
        applyStimulus(1, 16, 1'b1, 1'b0, 0);
        checkOutput("timeoutClearB", int'(busB.timeout), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, -16, 1'b0, 1'b0, 0);
        applyStimulus(1, 16, 1'b1, 1'b1, 5);
        checkQueues("timeout");
        checkOutput("timeoutHeldB", int'(busB.period_out), 5);

        $display("[TB] reset in the middle of the sine");
        doReset();
        buildSine(3, 1);
        applyVecs(22);
        checkQueues("preReset");
        checkOutput("preResetPeriod", int'(busA.period_out), 9);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("asyncReset", 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        buildSine(2, 1);
        applyVecs(vecs.size());
        checkQueues("postReset");
        checkOutput("postResetPeriod", int'(busA.period_out), 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
